tiny_soc_mem_arbiter: RTL and testbench
=======================================

# tiny_soc_mem_arbiter

Two-requester round-robin arbiter sharing the tiny SoC's single-port 64-bit SRAM between the Rocket memory port (port 0) and a loader/debug port (port 1). It relocates byte addresses into SRAM word indices and expands byte strobes to bit masks. It returns a one-cycle-latency response, with an error flag, to whichever port was granted. It sits between `rocket_mem_top`/loader and `noift_sram_mem`, replacing the direct wiring.

## Interface
- `NumWords`, 1<<17: SRAM depth in 64-bit words.
- `AddrWidth`, 32: requester byte-address width.
- `DataWidth`, 64: data width; fixed at 64 (8 strobe bits).
- `BaseAddr`, 32'h8000_0000: byte address of SRAM word 0.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous reset, active-high.
- `req_i`  in  [1:0]  per-port request.
- `we_i`  in  [1:0]  per-port write enable.
- `addr_i`  in  2×AddrWidth  per-port byte address.
- `be_i`  in  2×8  per-port byte strobes.
- `wdata_i`  in  2×DataWidth  per-port write data.
- `gnt_o`  out  [1:0]  per-port grant, combinational, same cycle as the request.
- `rvalid_o`  out  [1:0]  per-port response valid, one cycle after the grant.
- `rdata_o`  out  DataWidth  response data, shared by both ports.
- `err_o`  out  1  response is out-of-range; qualified by `rvalid_o`.
- `sram_req_o`  out  1  SRAM access.
- `sram_we_o`  out  1  SRAM write.
- `sram_addr_o`  out  $clog2(NumWords)  SRAM word index.
- `sram_wdata_o`  out  DataWidth  SRAM write data.
- `sram_wmask_o`  out  DataWidth  SRAM bit mask.
- `sram_rdata_i`  in  DataWidth  SRAM read data, valid the cycle after `sram_req_o`.
- `conflict_cnt_o`  out  32  saturating count of cycles with both ports requesting.

## Operation
- Exactly one port is granted per cycle when any `req_i` bit is high. Requests are never stalled beyond the arbitration loss.
- Round-robin pointer `prio_q` names the preferred port.
  - Single requester: that port wins.
  - Both requesting: port `prio_q` wins.
  - After any grant to port p, `prio_q` ← ~p.
  - No grant: `prio_q` holds.
- A losing requester keeps `req_i` and its payload stable until granted.
- Relocation: `off = addr - BaseAddr` (AddrWidth, unsigned). The access is in range iff `addr >= BaseAddr` and `off[AddrWidth-1:3] < NumWords`. `sram_addr_o = off >> 3`; `addr[2:0]` is ignored.
- In-range grant:
  - `sram_req_o=1`.
  - `sram_we_o`, `sram_wdata_o` forwarded from the winner.
  - `sram_wmask_o` bit 8k+j = `be[k]`.
- Out-of-range grant: `sram_req_o=0`; the response carries `err_o=1` and `rdata_o=0`. Writes are dropped.
- Response register `rsp_q` holds `{valid, port, err}`, loaded every cycle from the grant decision. Next cycle:
  - `rvalid_o[port]=1`.
  - `rdata_o = err ? 0 : sram_rdata_i` (zero on writes too).
  - Writes also receive `rvalid` as an acknowledge.
- `conflict_cnt_o` increments when `req_i==2'b11`, saturating at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - `prio_q=0`, `rsp_q.valid=0`.
  - `gnt_o`/`sram_*` combinational from inputs; `rvalid_o=0`, `err_o=0`, `rdata_o=0` while in reset.
  - `conflict_cnt_o=0`.
- Request-to-response latency is exactly 1 cycle. Back-to-back grants are allowed every cycle (full throughput), including alternating ports.
- A grant in cycle N and its response in cycle N+1 may coexist with a new grant in N+1.
- Reset asserted mid-operation: a pending response is discarded, with no `rvalid` after reset deasserts. `prio_q` returns to port 0.
- While `rst_i` is high, `gnt_o` and `sram_req_o` are forced to 0.

## Structure
- Package `tiny_soc_mem_pkg`:
  - `addr_t`, `data_t`, `strb_t`.
  - `port_idx_t` (1 bit), `rsp_t` struct `{valid, port, err}`.
  - Function `strb_to_mask(strb_t) -> data_t`.
  - `NumPorts=2`.
- Sub-module `rr_arb2` (priority pointer + grant vector). The top handles relocation, muxing, response register and counter.

## Test plan
- Port 0 reads 0x8000_0010 alone → `gnt_o=01`, `sram_addr_o=2`; next cycle `rvalid_o=01`, `rdata_o` = SRAM word 2, `err_o=0`.
- Both ports request from reset (`prio_q=0`):
  - Port 0 is granted first; port 1 holds and is granted next cycle.
  - Subsequent simultaneous requests alternate 0/1.
  - `conflict_cnt_o` counts each both-high cycle.
- Port 1 writes 0x8000_0008, `be=8'b0000_0101`, data 0x1122334455667788 → `sram_wmask_o=64'h0000_0000_00FF_00FF`, `sram_addr_o=1`; ack next cycle with `rdata_o=0`.
- Out-of-range addresses:
  - Port 0 reads 0x7FFF_FFF8 → `sram_req_o=0`, next cycle `rvalid_o=01`, `err_o=1`, `rdata_o=0`.
  - 0x8010_0000 with NumWords=1<<17 → same error response.
- Continuous port-0 reads every cycle for 8 cycles → 8 consecutive `rvalid_o[0]` pulses with matching data, no bubbles.
- `rst_i` pulsed the cycle after a grant → no `rvalid` emitted; `conflict_cnt_o=0`; next simultaneous request grants port 0.

Source files
------------

// File: rtl/tiny_soc_mem_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter.
// Data width is fixed at 64 bits, so there are 8 byte strobes.
package tiny_soc_mem_pkg;

   localparam int unsigned NumPorts  = 2;
   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned StrbWidth = DataWidth / 8;

   typedef logic [AddrWidth-1:0] addr_t;
   typedef logic [DataWidth-1:0] data_t;
   typedef logic [StrbWidth-1:0] strb_t;
   typedef logic                 port_idx_t;

   typedef struct packed {
      logic      valid;
      port_idx_t port;
      logic      err;
   } rsp_t;

   // Each byte strobe k covers bits [8k+7:8k] of the mask.
   function automatic data_t strb_to_mask(strb_t strb);
      data_t mask;
      for (int k = 0; k < int'(StrbWidth); k++) begin
         mask[8*k +: 8] = {8{strb[k]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/tiny_soc_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SRAM.
// Handshake: a request transfers in the cycle where req_i[p] & gnt_o[p] are both high.
// Until then the requester holds req_i[p] and its payload stable. The response is
// rvalid_o[p] exactly one cycle later, and it cannot be back-pressured.
interface tiny_soc_mem_arbiter_if
   import tiny_soc_mem_pkg::*;
#(
   parameter int unsigned SramAw = 17
) ();

   logic  [NumPorts-1:0] req_i;
   logic  [NumPorts-1:0] we_i;
   addr_t [NumPorts-1:0] addr_i;
   strb_t [NumPorts-1:0] be_i;
   data_t [NumPorts-1:0] wdata_i;

   logic  [NumPorts-1:0] gnt_o;
   logic  [NumPorts-1:0] rvalid_o;
   data_t                rdata_o;
   logic                 err_o;

   logic                 sram_req_o;
   logic                 sram_we_o;
   logic  [SramAw-1:0]   sram_addr_o;
   data_t                sram_wdata_o;
   data_t                sram_wmask_o;
   data_t                sram_rdata_i;

   logic  [31:0]         conflict_cnt_o;
   port_idx_t            dbg_prio;

   modport slave (
      input  req_i, we_i, addr_i, be_i, wdata_i, sram_rdata_i,
      output gnt_o, rvalid_o, rdata_o, err_o,
      output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
      output conflict_cnt_o, dbg_prio
   );

   modport master (
      output req_i, we_i, addr_i, be_i, wdata_i, sram_rdata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o,
      input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
      input  conflict_cnt_o, dbg_prio
   );

endinterface

// File: rtl/tiny_soc_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-bit priority pointer plus a combinational grant.
// The pointer names the port that wins a tie; it flips away from every winner.
module rr_arb2
   import tiny_soc_mem_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       any_gnt,
   output port_idx_t  winner,
   output port_idx_t  prio
);

   port_idx_t prio_q;
   port_idx_t prio_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

   always_comb begin
      prio_d = prio_q;
      if (any_gnt) begin
         prio_d = ~winner;
      end
   end

   // Grants are suppressed while reset is held so nothing reaches the SRAM.
   always_comb begin
      gnt     = 2'b00;
      any_gnt = 1'b0;
      winner  = prio_q;
      if (!rst_i && (req != 2'b00)) begin
         any_gnt = 1'b1;
         if (req == 2'b11) begin
            winner = prio_q;
         end else begin
            winner = req[1];
         end
         gnt[winner] = 1'b1;
      end
   end

   assign prio = prio_q;

endmodule

// File: rtl/tiny_soc_mem_arbiter.sv
// Shares one 64-bit single-port SRAM between the Rocket port (0) and the loader port (1).
// It relocates byte addresses to word indices and returns a response one cycle after each grant.
module tiny_soc_mem_arbiter
   import tiny_soc_mem_pkg::*;
#(
   parameter int unsigned NumWords = 1 << 17,
   parameter addr_t       BaseAddr = 32'h8000_0000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   tiny_soc_mem_arbiter_if.slave bus
);

   localparam int unsigned SramAw = $clog2(NumWords);

   logic [1:0] gnt;
   logic       any_gnt;
   port_idx_t  winner;
   port_idx_t  prio;

   rr_arb2 u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req     (bus.req_i),
      .gnt     (gnt),
      .any_gnt (any_gnt),
      .winner  (winner),
      .prio    (prio)
   );

   assign bus.gnt_o    = gnt;
   assign bus.dbg_prio = prio;

   addr_t win_addr;
   addr_t win_off;
   addr_t word_idx;
   logic  in_range;
   logic  win_we;

   // The offset wraps below BaseAddr, so the lower bound is checked on the raw address.
   always_comb begin
      win_addr = bus.addr_i[winner];
      win_we   = bus.we_i[winner];
      win_off  = win_addr - BaseAddr;
      word_idx = win_off >> 3;
      in_range = (win_addr >= BaseAddr) && (word_idx < addr_t'(NumWords));
   end

   assign bus.sram_req_o   = any_gnt & in_range;
   assign bus.sram_we_o    = any_gnt & in_range & win_we;
   assign bus.sram_addr_o  = word_idx[SramAw-1:0];
   assign bus.sram_wdata_o = bus.wdata_i[winner];
   assign bus.sram_wmask_o = strb_to_mask(bus.be_i[winner]);

   rsp_t rsp_d;
   rsp_t rsp_q;
   logic rsp_we_q;

   always_comb begin
      rsp_d.valid = any_gnt;
      rsp_d.port  = winner;
      rsp_d.err   = ~in_range;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_q    <= '0;
         rsp_we_q <= 1'b0;
      end else begin
         rsp_q    <= rsp_d;
         rsp_we_q <= win_we;
      end
   end

   // Write acks and errors return zero data rather than whatever the SRAM drives.
   always_comb begin
      bus.rvalid_o = 2'b00;
      bus.err_o    = 1'b0;
      bus.rdata_o  = '0;
      if (rsp_q.valid) begin
         bus.rvalid_o[rsp_q.port] = 1'b1;
         bus.err_o                = rsp_q.err;
         if (!rsp_q.err && !rsp_we_q) begin
            bus.rdata_o = bus.sram_rdata_i;
         end
      end
   end

   logic [31:0] conflict_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         conflict_cnt_q <= '0;
      end else if ((bus.req_i == 2'b11) && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
         conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
   end

   assign bus.conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_tiny_soc_mem_arbiter.sv
// Bench for tiny_soc_mem_arbiter: directed scenarios plus random two-port traffic.
// A behavioural model of grants, relocation and memory contents is checked every cycle.
module tb_tiny_soc_mem_arbiter;
   import tiny_soc_mem_pkg::*;

   localparam int unsigned NW   = 1 << 17;
   localparam addr_t       BASE = 32'h8000_0000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tiny_soc_mem_arbiter_if #(.SramAw(17)) bus ();

   tiny_soc_mem_arbiter #(.NumWords(NW), .BaseAddr(BASE)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic data_t init_word(input int unsigned idx);
      logic [31:0] i;
      i = idx;
      return {i ^ 32'hA5A5_5A5A, i * 32'h9E37_79B1};
   endfunction

   // ---------------- SRAM environment ----------------
   data_t env_mem [int unsigned];
   always @(posedge clk) begin : sram_env
      data_t       w;
      int unsigned a;
      if (bus.sram_req_o) begin
         a = int'(bus.sram_addr_o);
         w = env_mem.exists(a) ? env_mem[a] : init_word(a);
         if (bus.sram_we_o) env_mem[a] = (w & ~bus.sram_wmask_o) | (bus.sram_wdata_o & bus.sram_wmask_o);
         else bus.sram_rdata_i <= w;
      end
   end

   // ---------------- behavioural model ----------------
   data_t       m_mem [int unsigned];
   int          m_prio = 0;
   logic [31:0] m_cnt  = 0;
   logic [1:0]  m_gnt  = 2'b00;
   logic        r_valid = 1'b0;
   int          r_port  = 0;
   logic        r_err   = 1'b0;
   data_t       r_data  = '0;

   function automatic data_t m_read(input int unsigned idx);
      return m_mem.exists(idx) ? m_mem[idx] : init_word(idx);
   endfunction

   always @(negedge clk) begin : model_cmp
      int          w;
      logic        inr;
      addr_t       a;
      addr_t       off;
      logic [31:0] idx;
      data_t       emask;
      data_t       wd;
      if (rst) begin
         chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
         chk("rst_sram_req", 64'(bus.sram_req_o), 64'd0);
         chk("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
         chk("rst_err", 64'(bus.err_o), 64'd0);
         chk("rst_rdata", bus.rdata_o, 64'd0);
         chk("rst_cnt", 64'(bus.conflict_cnt_o), 64'd0);
         r_valid = 1'b0;
         m_prio  = 0;
         m_cnt   = 0;
         m_gnt   = 2'b00;
      end else begin
         chk("rvalid", 64'(bus.rvalid_o), r_valid ? ((r_port == 0) ? 64'd1 : 64'd2) : 64'd0);
         if (r_valid) begin
            chk("err", 64'(bus.err_o), 64'(r_err));
            chk("rdata", bus.rdata_o, r_data);
         end
         chk("conflict_cnt", 64'(bus.conflict_cnt_o), 64'(m_cnt));
         w = -1;
         if (bus.req_i == 2'b01) w = 0;
         else if (bus.req_i == 2'b10) w = 1;
         else if (bus.req_i == 2'b11) w = m_prio;
         m_gnt = 2'b00;
         if (w >= 0) m_gnt[w] = 1'b1;
         chk("gnt", 64'(bus.gnt_o), 64'(m_gnt));
         if (w < 0) begin
            chk("sram_req_idle", 64'(bus.sram_req_o), 64'd0);
            r_valid = 1'b0;
         end else begin
            a   = bus.addr_i[w];
            off = a - BASE;
            idx = off / 8;
            inr = (a >= BASE) && (idx < NW);
            chk("sram_req", 64'(bus.sram_req_o), 64'(inr));
            if (inr) begin
               chk("sram_addr", 64'(bus.sram_addr_o), 64'(idx));
               chk("sram_we", 64'(bus.sram_we_o), 64'(bus.we_i[w]));
               if (bus.we_i[w]) begin
                  for (int k = 0; k < 8; k++) emask[8*k +: 8] = bus.be_i[w][k] ? 8'hFF : 8'h00;
                  chk("sram_wmask", bus.sram_wmask_o, emask);
                  chk("sram_wdata", bus.sram_wdata_o, bus.wdata_i[w]);
                  wd = m_read(idx);
                  for (int k = 0; k < 8; k++) if (bus.be_i[w][k]) wd[8*k +: 8] = bus.wdata_i[w][8*k +: 8];
                  m_mem[idx] = wd;
               end
            end
            r_valid = 1'b1;
            r_port  = w;
            r_err   = !inr;
            r_data  = (inr && !bus.we_i[w]) ? m_read(idx) : 64'd0;
            m_prio  = 1 - w;
         end
         if ((bus.req_i == 2'b11) && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      bus.req_i   = 2'b00;
      bus.we_i    = 2'b00;
      bus.addr_i  = '0;
      bus.be_i    = '0;
      bus.wdata_i = '0;
   endtask

   task automatic set_req(input int p, input logic w, input addr_t a, input strb_t b, input data_t d);
      bus.req_i[p]   = 1'b1;
      bus.we_i[p]    = w;
      bus.addr_i[p]  = a;
      bus.be_i[p]    = b;
      bus.wdata_i[p] = d;
   endtask

   task automatic at_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic at_sample();
      @(negedge clk);
      #1;
   endtask

   function automatic addr_t rand_addr();
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
         0:       return BASE - addr_t'(8 * $urandom_range(1, 4));
         1:       return BASE + addr_t'(NW * 8) + addr_t'(8 * $urandom_range(0, 3));
         2:       return BASE + addr_t'((NW - 1 - $urandom_range(0, 3)) * 8);
         default: return BASE + addr_t'(8 * $urandom_range(0, 31)) + addr_t'($urandom_range(0, 7));
      endcase
   endfunction

   // ---------------- stimulus ----------------
   logic  p_act [2];
   logic  p_we  [2];
   addr_t p_addr[2];
   strb_t p_be  [2];
   data_t p_data[2];
   int    pulses;

   initial begin
      clear_inputs();
      bus.sram_rdata_i = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // single read on port 0
      set_req(0, 1'b0, BASE + 32'h10, 8'hFF, 64'd0);
      at_sample();
      chk("t1_gnt", 64'(bus.gnt_o), 64'h1);
      chk("t1_sram_addr", 64'(bus.sram_addr_o), 64'd2);
      chk("t1_sram_req", 64'(bus.sram_req_o), 64'd1);
      at_drive();
      clear_inputs();
      at_sample();
      chk("t1_rvalid", 64'(bus.rvalid_o), 64'h1);
      chk("t1_err", 64'(bus.err_o), 64'd0);
      chk("t1_rdata", bus.rdata_o, init_word(2));

      // simultaneous requests straight after reset
      at_drive();
      rst = 1'b1;
      at_drive();
      rst = 1'b0;
      set_req(0, 1'b0, BASE + 32'h18, 8'hFF, 64'd0);
      set_req(1, 1'b0, BASE + 32'h20, 8'hFF, 64'd0);
      at_sample();
      chk("t2_gnt_first", 64'(bus.gnt_o), 64'h1);
      at_drive();
      bus.req_i[0] = 1'b0;
      at_sample();
      chk("t2_gnt_held", 64'(bus.gnt_o), 64'h2);
      chk("t2_rvalid0", 64'(bus.rvalid_o), 64'h1);
      at_drive();
      set_req(0, 1'b0, BASE + 32'h28, 8'hFF, 64'd0);
      set_req(1, 1'b0, BASE + 32'h30, 8'hFF, 64'd0);
      for (int i = 0; i < 4; i++) begin
         at_sample();
         chk("t2_alt_gnt", 64'(bus.gnt_o), (i % 2 == 0) ? 64'h1 : 64'h2);
         chk("t2_alt_rvalid", 64'(bus.rvalid_o), (i % 2 == 0) ? 64'h2 : 64'h1);
         at_drive();
      end
      clear_inputs();
      at_sample();
      chk("t2_conflicts", 64'(bus.conflict_cnt_o), 64'd5);

      // byte-strobed write on port 1, then read back
      at_drive();
      set_req(1, 1'b1, BASE + 32'h8, 8'b0000_0101, 64'h1122_3344_5566_7788);
      at_sample();
      chk("t3_wmask", bus.sram_wmask_o, 64'h0000_0000_00FF_00FF);
      chk("t3_sram_addr", 64'(bus.sram_addr_o), 64'd1);
      chk("t3_sram_we", 64'(bus.sram_we_o), 64'd1);
      at_drive();
      clear_inputs();
      set_req(0, 1'b0, BASE + 32'h8, 8'hFF, 64'd0);
      at_sample();
      chk("t3_ack", 64'(bus.rvalid_o), 64'h2);
      chk("t3_ack_rdata", bus.rdata_o, 64'd0);
      at_drive();
      clear_inputs();
      at_sample();
      chk("t3_readback", bus.rdata_o,
          (init_word(1) & ~64'h0000_0000_00FF_00FF) | (64'h1122_3344_5566_7788 & 64'h0000_0000_00FF_00FF));

      // out-of-range on both sides of the window
      at_drive();
      set_req(0, 1'b0, 32'h7FFF_FFF8, 8'hFF, 64'd0);
      at_sample();
      chk("t4_low_sram_req", 64'(bus.sram_req_o), 64'd0);
      at_drive();
      set_req(0, 1'b0, 32'h8010_0000, 8'hFF, 64'd0);
      at_sample();
      chk("t4_low_rvalid", 64'(bus.rvalid_o), 64'h1);
      chk("t4_low_err", 64'(bus.err_o), 64'd1);
      chk("t4_low_rdata", bus.rdata_o, 64'd0);
      chk("t4_high_sram_req", 64'(bus.sram_req_o), 64'd0);
      at_drive();
      clear_inputs();
      at_sample();
      chk("t4_high_err", 64'(bus.err_o), 64'd1);
      chk("t4_high_rdata", bus.rdata_o, 64'd0);

      // eight back-to-back reads on port 0
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         at_drive();
         set_req(0, 1'b0, BASE + addr_t'(8 * (10 + i)), 8'hFF, 64'd0);
         at_sample();
         if (i > 0 && bus.rvalid_o[0]) pulses++;
      end
      at_drive();
      clear_inputs();
      at_sample();
      if (bus.rvalid_o[0]) pulses++;
      chk("t5_pulses", 64'(pulses), 64'd8);

      // reset right after a grant drops the response
      at_drive();
      set_req(0, 1'b0, BASE + 32'hA0, 8'hFF, 64'd0);
      at_drive();
      rst = 1'b1;
      clear_inputs();
      at_sample();
      chk("t6_rvalid_in_rst", 64'(bus.rvalid_o), 64'd0);
      at_drive();
      rst = 1'b0;
      at_sample();
      chk("t6_rvalid_after", 64'(bus.rvalid_o), 64'd0);
      chk("t6_cnt", 64'(bus.conflict_cnt_o), 64'd0);
      at_drive();
      set_req(0, 1'b0, BASE + 32'hA8, 8'hFF, 64'd0);
      set_req(1, 1'b0, BASE + 32'hB0, 8'hFF, 64'd0);
      at_sample();
      chk("t6_gnt", 64'(bus.gnt_o), 64'h1);
      at_drive();
      clear_inputs();

      // random traffic
      for (int p = 0; p < 2; p++) p_act[p] = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         at_drive();
         for (int p = 0; p < 2; p++) begin
            if (p_act[p] && m_gnt[p]) p_act[p] = 1'b0;
            if (!p_act[p] && ($urandom_range(0, 9) < 6)) begin
               p_act[p]  = 1'b1;
               p_we[p]   = ($urandom_range(0, 2) == 0);
               p_addr[p] = rand_addr();
               p_be[p]   = strb_t'($urandom_range(0, 255));
               p_data[p] = {$urandom, $urandom};
            end
            if (p_act[p]) set_req(p, p_we[p], p_addr[p], p_be[p], p_data[p]);
            else bus.req_i[p] = 1'b0;
         end
         rst = ($urandom_range(0, 99) == 0);
      end
      at_drive();
      rst = 1'b0;
      clear_inputs();
      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
